// File: rtl/iiitb_pwm_capture_pkg.sv
// Shared types and constants for the iiitb PWM generator / capture pair.
package iiitb_pwm_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int DUTY_W    = 7;
    localparam int PCT_SCALE = 100;
    localparam int DIV_STEPS = 7;

    // Generator defaults, so loopback checks speak the same units.
    localparam int GEN_DUTY_STEP = 10;
    localparam int GEN_PERIOD    = 10;

endpackage

// File: rtl/iiitb_pwm_capture_div.sv
// Sequential restoring divider: quot = floor(num / den), one quotient bit per cycle.
// Relies on num < 2^DIV_STEPS * den, which holds because high time never exceeds period.
module iiitb_pwm_div
    import iiitb_pwm_pkg::*;
#(
    parameter int NUM_W = 23,
    parameter int DEN_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [NUM_W-1:0]  num,
    input  logic [DEN_W-1:0]  den,
    output logic              busy,
    output logic              done,
    output logic [DUTY_W-1:0] quot
);
    localparam int                STEP_W    = $clog2(DIV_STEPS);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(DIV_STEPS - 1);

    logic [NUM_W-1:0]  r_rem;
    logic [NUM_W-1:0]  r_den_sh;
    logic [DUTY_W-2:0] r_q;
    logic [STEP_W-1:0] r_step;
    logic              r_busy;
    logic              w_ge;
    logic [NUM_W-1:0]  w_den_ext;

    assign w_den_ext = NUM_W'(den);
    assign w_ge      = (r_rem >= r_den_sh);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem    <= '0;
            r_den_sh <= '0;
            r_q      <= '0;
            r_step   <= '0;
            r_busy   <= 1'b0;
        end else if (r_busy) begin
            if (w_ge) begin
                r_rem <= r_rem - r_den_sh;
            end
            r_den_sh <= r_den_sh >> 1;
            r_q      <= {r_q[DUTY_W-3:0], w_ge};
            r_step   <= r_step + STEP_W'(1);
            if (r_step == LAST_STEP) begin
                r_busy <= 1'b0;
            end
        end else if (start) begin
            r_rem    <= num;
            r_den_sh <= w_den_ext << (DIV_STEPS - 1);
            r_q      <= '0;
            r_step   <= '0;
            r_busy   <= 1'b1;
        end
    end

    // The final quotient bit is resolved combinationally in the last step.
    assign busy = r_busy;
    assign done = r_busy && (r_step == LAST_STEP);
    assign quot = {r_q, w_ge};

endmodule

// File: rtl/iiitb_pwm_capture.sv
// PWM capture: measures period, high time and duty percentage of an asynchronous PWM input.
//   state | meaning
//   IDLE  | waiting for the first rising edge; counters held at 0
//   RUN   | counting between rising edges; each rise captures and reloads
module iiitb_pwm_capture
    import iiitb_pwm_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pwm_in,
    output logic [CNT_W-1:0]  period_out,
    output logic [CNT_W-1:0]  high_out,
    output logic [DUTY_W-1:0] duty_pct,
    output logic              meas_valid,
    output logic              stuck,
    output logic              overrun,
    output logic              busy
);
    localparam int               NUM_W   = CNT_W + DIV_STEPS;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [SYNC_STAGES-1:0]   r_sync;
    logic                     r_pwm_d;
    logic [CNT_W-1:0]         r_per;
    logic [CNT_W-1:0]         r_hi;
    logic [CNT_W-1:0]         r_cap_per;
    logic [CNT_W-1:0]         r_cap_hi;
    logic                     w_pwm_s;
    logic                     w_rise;
    logic                     w_timeout;
    logic                     w_start;
    logic                     w_div_busy;
    logic                     w_div_done;
    logic [DUTY_W-1:0]        w_quot;
    logic [NUM_W-1:0]         w_num;

    assign w_pwm_s   = r_sync[SYNC_STAGES-1];
    assign w_rise    = w_pwm_s & ~r_pwm_d;
    assign w_timeout = (r_state == RUN) && !w_rise && (r_per == CNT_MAX);
    assign w_start   = (r_state == RUN) && w_rise && !w_div_busy;
    assign w_num     = NUM_W'(r_hi) * NUM_W'(PCT_SCALE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync  <= '0;
            r_pwm_d <= 1'b0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], pwm_in};
            r_pwm_d <= w_pwm_s;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_rise)    w_state_nxt = RUN;
            RUN:     if (w_timeout) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // A rise always reloads, even when its capture is dropped for overrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_per <= '0;
            r_hi  <= '0;
        end else if (w_rise) begin
            r_per <= CNT_ONE;
            r_hi  <= CNT_ONE;
        end else if (r_state == IDLE || w_timeout) begin
            r_per <= '0;
            r_hi  <= '0;
        end else begin
            if (r_per != CNT_MAX) begin
                r_per <= r_per + CNT_ONE;
            end
            if (w_pwm_s && (r_hi != CNT_MAX)) begin
                r_hi <= r_hi + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cap_per <= '0;
            r_cap_hi  <= '0;
            overrun   <= 1'b0;
        end else begin
            if (w_start) begin
                r_cap_per <= r_per;
                r_cap_hi  <= r_hi;
            end
            if ((r_state == RUN) && w_rise && w_div_busy) begin
                overrun <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_out <= '0;
            high_out   <= '0;
            duty_pct   <= '0;
            meas_valid <= 1'b0;
            stuck      <= 1'b0;
        end else if (w_div_done) begin
            period_out <= r_cap_per;
            high_out   <= r_cap_hi;
            duty_pct   <= w_quot;
            meas_valid <= 1'b1;
            stuck      <= 1'b0;
        end else if (w_timeout) begin
            period_out <= '0;
            high_out   <= '0;
            duty_pct   <= w_pwm_s ? DUTY_W'(PCT_SCALE) : '0;
            meas_valid <= 1'b1;
            stuck      <= 1'b1;
        end else begin
            meas_valid <= 1'b0;
        end
    end

    assign busy = w_div_busy;

    iiitb_pwm_div #(
        .NUM_W (NUM_W),
        .DEN_W (CNT_W)
    ) u_div (
        .clk   (clk),
        .rst_n (rst_n),
        .start (w_start),
        .num   (w_num),
        .den   (r_per),
        .busy  (w_div_busy),
        .done  (w_div_done),
        .quot  (w_quot)
    );

endmodule
